// File: rtl/divider_512_256_if.sv
// Request/response bundle for the 512/256 restoring divider.
// start is sampled only while the divider is idle (including the done cycle); busy rises on the
// accepting edge and falls on the edge that raises done; done is a one-cycle pulse with quot/rem/div_zero valid.
interface divider_512_256_if #(
   parameter int DIVIDEND_W = 512,
   parameter int DIVISOR_W  = 256
);
   logic                  start;
   logic [DIVIDEND_W-1:0] in1;
   logic [DIVISOR_W-1:0]  in2;
   logic [DIVIDEND_W-1:0] quot;
   logic [DIVISOR_W-1:0]  rem;
   logic                  div_zero;
   logic                  busy;
   logic                  done;

   modport master (
      output start, in1, in2,
      input  quot, rem, div_zero, busy, done
   );

   modport slave (
      input  start, in1, in2,
      output quot, rem, div_zero, busy, done
   );
endinterface

// File: rtl/divider_512_256.sv
// Sequential radix-2 restoring divider: 512-bit dividend by 256-bit divisor,
// one quotient bit per clock, with divide-by-zero short cut.
module divider_512_256 #(
   parameter int DIVIDEND_W = 512,
   parameter int DIVISOR_W  = 256,
   parameter int CNT_W      = 10
) (
   input  logic             clk,
   input  logic             reset,
   divider_512_256_if.slave bus,
   output logic [1:0]       state_dbg
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CALC   = 2'd1,
      FINISH = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIVIDEND_W - 1);

   state_t                state;
   logic [DIVIDEND_W-1:0] d_reg;
   logic [DIVISOR_W-1:0]  v_reg;
   logic [DIVISOR_W-1:0]  r_reg;
   logic [DIVIDEND_W-1:0] q_reg;
   logic [CNT_W-1:0]      cnt;
   logic                  zero_flag;
   logic [DIVIDEND_W-1:0] quot_r;
   logic [DIVISOR_W-1:0]  rem_r;
   logic                  dz_r;
   logic                  busy_r;
   logic                  done_r;

   // The partial remainder stays below V, so only the trial value needs the
   // extra bit; the difference is exact in DIVISOR_W bits whenever it is kept.
   logic [DIVISOR_W:0]    trial;
   logic [DIVISOR_W-1:0]  diff;
   logic                  fits;

   always_comb begin
      trial = {r_reg, d_reg[DIVIDEND_W-1]};
      fits  = (trial >= {1'b0, v_reg});
      diff  = trial[DIVISOR_W-1:0] - v_reg;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         d_reg     <= '0;
         v_reg     <= '0;
         r_reg     <= '0;
         q_reg     <= '0;
         cnt       <= '0;
         zero_flag <= 1'b0;
         quot_r    <= '0;
         rem_r     <= '0;
         dz_r      <= 1'b0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done_r <= 1'b0;
               if (bus.start) begin
                  d_reg  <= bus.in1;
                  v_reg  <= bus.in2;
                  cnt    <= '0;
                  busy_r <= 1'b1;
                  if (bus.in2 == '0) begin
                     // Preload the defined divide-by-zero result and skip iteration.
                     zero_flag <= 1'b1;
                     q_reg     <= '1;
                     r_reg     <= bus.in1[DIVISOR_W-1:0];
                     state     <= FINISH;
                  end else begin
                     zero_flag <= 1'b0;
                     q_reg     <= '0;
                     r_reg     <= '0;
                     state     <= CALC;
                  end
               end
            end
            CALC: begin
               d_reg <= d_reg << 1;
               r_reg <= fits ? diff : trial[DIVISOR_W-1:0];
               q_reg <= {q_reg[DIVIDEND_W-2:0], fits};
               cnt   <= cnt + 1'b1;
               if (cnt == LAST_CNT) state <= FINISH;
            end
            FINISH: begin
               quot_r <= q_reg;
               rem_r  <= r_reg;
               dz_r   <= zero_flag;
               done_r <= 1'b1;
               busy_r <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.quot     = quot_r;
   assign bus.rem      = rem_r;
   assign bus.div_zero = dz_r;
   assign bus.busy     = busy_r;
   assign bus.done     = done_r;
   assign state_dbg    = state;

endmodule

// File: tb/tb_divider_512_256.sv
// Directed and random checks of divider_512_256 against values the bench builds itself
// (dividend formed as A*B+C so quotient A and remainder C are known by construction).
module tb_divider_512_256;
   localparam int DW = 512;
   localparam int VW = 256;

   logic       clk;
   logic       reset;
   logic [1:0] state_dbg;

   divider_512_256_if #(.DIVIDEND_W(DW), .DIVISOR_W(VW)) bus ();

   divider_512_256 dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .state_dbg (state_dbg)
   );

   int total = 0;
   int bad   = 0;

   logic [DW-1:0] exp_quot_q[$];
   logic [VW-1:0] exp_rem_q[$];
   logic          exp_dz_q[$];
   logic [DW-1:0] last_quot;
   logic [VW-1:0] last_rem;
   logic          last_dz;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [VW-1:0] rand256();
      logic [VW-1:0] r = '0;
      for (int i = 0; i < 8; i++) r = {r[VW-33:0], 32'($urandom())};
      return r;
   endfunction

   // Builds in1 = A*B + C with B != 0 and C < B, so quot = A and rem = C.
   task automatic make_vec(output logic [DW-1:0] in1, output logic [VW-1:0] in2,
                           output logic [DW-1:0] eq, output logic [VW-1:0] er);
      logic [VW-1:0] a, b, c;
      a = rand256();
      b = rand256();
      if ($urandom_range(0, 2) == 0) b = b >> $urandom_range(1, 250);
      if (b == '0) b = 256'd1;
      c = rand256() % b;
      in1 = {256'd0, a} * {256'd0, b} + {256'd0, c};
      in2 = b;
      eq  = {256'd0, a};
      er  = c;
   endtask

   task automatic drive_op(input logic [DW-1:0] in1, input logic [VW-1:0] in2,
                           input logic [DW-1:0] eq, input logic [VW-1:0] er, input logic edz);
      bus.start = 1'b1;
      bus.in1   = in1;
      bus.in2   = in2;
      exp_quot_q.push_back(eq);
      exp_rem_q.push_back(er);
      exp_dz_q.push_back(edz);
      @(negedge clk);
      bus.start = 1'b0;
      bus.in1   = ~in1;
      bus.in2   = ~in2;
   endtask

   task automatic compare_result(input string tag);
      total++;
      assert (exp_quot_q.size() > 0) else begin
         bad++;
         $error("FAIL %s unexpected_done observed=1 expected=0", tag);
      end
      if (exp_quot_q.size() > 0) begin
         last_quot = exp_quot_q.pop_front();
         last_rem  = exp_rem_q.pop_front();
         last_dz   = exp_dz_q.pop_front();
         check({tag, " quot"}, bus.quot, last_quot);
         check({tag, " rem"}, DW'(bus.rem), DW'(last_rem));
         check({tag, " div_zero"}, DW'(bus.div_zero), DW'(last_dz));
      end
   endtask

   task automatic wait_done(input int exp_lat, input string tag);
      int cycles = 0;
      bit busy_drop = 1'b0;
      while (bus.done !== 1'b1 && cycles < 700) begin
         if (bus.busy !== 1'b1) busy_drop = 1'b1;
         @(negedge clk);
         cycles++;
      end
      check({tag, " latency"}, DW'(cycles), DW'(exp_lat));
      check({tag, " busy_drop"}, DW'(busy_drop), '0);
      check({tag, " busy_at_done"}, DW'(bus.busy), '0);
      compare_result(tag);
      @(negedge clk);
      check({tag, " done_width"}, DW'(bus.done), '0);
      check({tag, " quot_hold"}, bus.quot, last_quot);
   endtask

   task automatic run_op(input logic [DW-1:0] in1, input logic [VW-1:0] in2,
                         input logic [DW-1:0] eq, input logic [VW-1:0] er, input logic edz,
                         input int lat, input string tag);
      drive_op(in1, in2, eq, er, edz);
      wait_done(lat, tag);
   endtask

   logic [DW-1:0] a_in1, b_in1, c_in1, a_q, b_q, c_q;
   logic [VW-1:0] a_in2, b_in2, c_in2, a_r, b_r, c_r;
   logic [DW-1:0] all_ones;
   bit            done_seen;

   initial begin
      reset     = 1'b0;
      bus.start = 1'b0;
      bus.in1   = '0;
      bus.in2   = '0;
      all_ones  = '1;
      repeat (3) @(negedge clk);
      check("rst quot", bus.quot, '0);
      check("rst rem", DW'(bus.rem), '0);
      check("rst div_zero", DW'(bus.div_zero), '0);
      check("rst busy", DW'(bus.busy), '0);
      check("rst done", DW'(bus.done), '0);
      check("rst state", DW'(state_dbg), '0);
      reset = 1'b1;
      @(negedge clk);

      run_op(512'd100, 256'd7, 512'd14, 256'd2, 1'b0, 513, "small");
      run_op(512'h1234, 256'd0, all_ones, 256'h1234, 1'b1, 1, "div0");
      run_op(all_ones, 256'd1, all_ones, 256'd0, 1'b0, 513, "max_by_one");
      run_op(all_ones, {VW{1'b1}}, (512'd1 << 256) + 512'd1, 256'd0, 1'b0, 513, "max_by_max");

      // Back-to-back with an ignored mid-calculation start.
      make_vec(a_in1, a_in2, a_q, a_r);
      make_vec(b_in1, b_in2, b_q, b_r);
      drive_op(a_in1, a_in2, a_q, a_r, 1'b0);
      repeat (100) @(negedge clk);
      bus.start = 1'b1;
      bus.in1   = 512'hBAD;
      bus.in2   = 256'd3;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (411) @(negedge clk);
      check("b2b finish_state", DW'(state_dbg), DW'(2'd2));
      bus.start = 1'b1;
      bus.in1   = b_in1;
      bus.in2   = b_in2;
      exp_quot_q.push_back(b_q);
      exp_rem_q.push_back(b_r);
      exp_dz_q.push_back(1'b0);
      @(negedge clk);
      check("b2b first_done", DW'(bus.done), DW'(1'b1));
      compare_result("b2b_first");
      @(negedge clk);
      bus.start = 1'b0;
      bus.in1   = '0;
      bus.in2   = '0;
      check("b2b accepted_busy", DW'(bus.busy), DW'(1'b1));
      check("b2b accepted_done", DW'(bus.done), '0);
      wait_done(513, "b2b_second");

      // Asynchronous reset in the middle of CALC.
      make_vec(c_in1, c_in2, c_q, c_r);
      drive_op(c_in1, c_in2, c_q, c_r, 1'b0);
      repeat (300) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      check("abort quot", bus.quot, '0);
      check("abort rem", DW'(bus.rem), '0);
      check("abort div_zero", DW'(bus.div_zero), '0);
      check("abort busy", DW'(bus.busy), '0);
      check("abort done", DW'(bus.done), '0);
      check("abort state", DW'(state_dbg), '0);
      exp_quot_q.delete();
      exp_rem_q.delete();
      exp_dz_q.delete();
      repeat (2) @(negedge clk);
      reset = 1'b1;
      done_seen = 1'b0;
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         if (bus.done === 1'b1) done_seen = 1'b1;
      end
      check("abort no_done", DW'(done_seen), '0);
      make_vec(c_in1, c_in2, c_q, c_r);
      run_op(c_in1, c_in2, c_q, c_r, 1'b0, 513, "after_reset");

      for (int n = 0; n < 40; n++) begin
         make_vec(a_in1, a_in2, a_q, a_r);
         run_op(a_in1, a_in2, a_q, a_r, 1'b0, 513, $sformatf("rand%0d", n));
      end

      check("queue_empty", DW'(exp_quot_q.size()), '0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
